mul_lopd_norm_pipe: RTL

//  Parametrised, pipelined leading-one position detector plus normaliser for the FPU_MUL datapath.

---
 rtl/mul_lopd_norm_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mul_lopd_norm_pipe.sv
// Two-stage leading-one detector and normaliser for the multiplier mantissa product.
// Stage 1 counts per byte; stage 2 merges the counts, applies the shift cap and shifts.
module mul_lopd_norm_pipe #(
  parameter  int unsigned WIDTH = 24,
  localparam int unsigned LZW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [LZW-1:0]   i_max_shift,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LZW-1:0]   o_lzc,
  output logic [WIDTH-1:0] o_norm,
  output logic             o_zero,
  output logic             o_limited
);

  localparam int unsigned NB = WIDTH / 8;

  if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("mul_lopd_norm_pipe: WIDTH must be a multiple of 8 in 8..64");
  end

  // {byte_is_zero, leading_zero_count} of one byte; highest set bit wins
  function automatic logic [3:0] byte_lzc(input logic [7:0] b);
    logic [3:0] r;
    r = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = {1'b0, 3'(7 - i)};
    end
    return r;
  endfunction

  logic                  v1;
  logic [WIDTH-1:0]      s1_data;
  logic [LZW-1:0]        s1_max;
  logic [NB-1:0][2:0]    s1_blzc;
  logic [NB-1:0]         s1_bzero;

  logic                  adv1_c;
  logic                  adv2_c;
  logic [NB-1:0][2:0]    blzc_c;
  logic [NB-1:0]         bzero_c;
  logic                  found_c;
  logic [LZW-1:0]        cnt_c;
  logic [LZW-1:0]        shift_c;
  logic                  limited_c;
  logic [WIDTH-1:0]      norm_c;

  // Elastic handshake: a stage moves when its successor is empty or draining
  always_comb begin
    adv2_c = ~o_valid | i_ready;
    adv1_c = ~v1 | adv2_c;
  end

  assign o_ready = adv1_c;

  // Byte index 0 is the most significant byte
  always_comb begin
    blzc_c  = '0;
    bzero_c = '0;
    for (int j = 0; j < int'(NB); j++) begin
      {bzero_c[j], blzc_c[j]} = byte_lzc(i_data[WIDTH-1-8*j -: 8]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1       <= 1'b0;
      s1_data  <= '0;
      s1_max   <= '0;
      s1_blzc  <= '0;
      s1_bzero <= '0;
    end else if (adv1_c) begin
      v1 <= i_valid;
      if (i_valid) begin
        s1_data  <= i_data;
        s1_max   <= i_max_shift;
        s1_blzc  <= blzc_c;
        s1_bzero <= bzero_c;
      end
    end
  end

  // First non-zero byte from the MSB gives the coarse count; cap then shift
  always_comb begin
    found_c = 1'b0;
    cnt_c   = '0;
    for (int j = 0; j < int'(NB); j++) begin
      if (!found_c && !s1_bzero[j]) begin
        found_c = 1'b1;
        cnt_c   = LZW'(8 * j) + LZW'(s1_blzc[j]);
      end
    end
    limited_c = found_c && (cnt_c > s1_max);
    shift_c   = limited_c ? s1_max : cnt_c;
    norm_c    = s1_data << shift_c;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_lzc     <= '0;
      o_norm    <= '0;
      o_zero    <= 1'b0;
      o_limited <= 1'b0;
    end else if (adv2_c) begin
      o_valid <= v1;
      if (v1) begin
        o_lzc     <= shift_c;
        o_norm    <= norm_c;
        o_zero    <= ~found_c;
        o_limited <= limited_c;
      end
    end
  end

endmodule
